// File: rtl/dff_sweep_pkg.sv
// Shared types and defaults for the flip-flop setup-time sweep sequencer.
// Optional per-step logging is enabled with the STEP_LOG_EN macro (see dff_setup_sweep_ctrl).
package dff_sweep_pkg;

   localparam int unsigned DefCodeW = 4;
   localparam int unsigned DefTick  = 10;

   typedef enum logic [3:0] {
      StIdle,
      StSettle,
      StPrime,
      StLow,
      StLaunch,
      StSample,
      StLog,
      StRecover,
      StDone
   } state_e;

endpackage

// File: rtl/sweep_sync2.sv
// W-wide two-flop synchronizer for DUT outputs that are asynchronous to clk.
// Synchronous active-high reset clears both stages to 0.
module sweep_sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         q      <= '0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/dff_setup_sweep_ctrl.sv
// Setup-time sweep sequencer: steps the clock-delay code MAX_CODE..0 and records, per channel,
// the lowest code that still captures. Define STEP_LOG_EN to add a per-step log handshake.
module dff_setup_sweep_ctrl
   import dff_sweep_pkg::*;
#(
   parameter int unsigned NCH      = 4,
   parameter int unsigned CODE_W   = DefCodeW,
   parameter int unsigned MAX_CODE = 10,
   parameter int unsigned TICK     = DefTick
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop_on_fail,
   output logic                  busy,
   output logic                  done,
   output logic                  tclk_o,
   output logic                  din_o,
   output logic [CODE_W-1:0]     delay_code_o,
   input  logic [NCH-1:0]        dout_i,
   output logic [NCH*CODE_W-1:0] min_code_o,
   output logic [NCH-1:0]        found_o,
   output logic [NCH-1:0]        prime_err_o
`ifdef STEP_LOG_EN
   ,
   output logic                  log_valid,
   input  logic                  log_ready,
   output logic [CODE_W-1:0]     log_code,
   output logic [NCH-1:0]        log_fail
`endif
);

   localparam int unsigned TickW = $clog2(TICK);
   localparam logic [CODE_W-1:0] MaxCode = CODE_W'(MAX_CODE);

   state_e                       state_q, state_d;
   logic [TickW-1:0]             tick_q, tick_d;
   logic [CODE_W-1:0]            code_q;
   logic                         stop_q;
   logic [NCH-1:0]               failed_q;
   logic [NCH-1:0][CODE_W-1:0]   min_code_q;
   logic [NCH-1:0]               found_q;
   logic [NCH-1:0]               prime_err_q;
   logic [NCH-1:0]               dout_s;
   logic                         phase_end;
   logic                         timed_phase;
   logic                         last_step;
   logic                         start_ok;

   sweep_sync2 #(
      .W (NCH)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (dout_i),
      .q   (dout_s)
   );

   assign phase_end   = (tick_q == TickW'(TICK - 1));
   assign timed_phase = (state_q inside {StSettle, StPrime, StLow, StLaunch, StSample, StRecover});
   assign last_step   = (code_q == '0) || (stop_q && (&failed_q));
   assign start_ok    = (state_q == StIdle) && start;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start)     state_d = StSettle;
         StSettle: if (phase_end) state_d = StPrime;
         StPrime:  if (phase_end) state_d = StLow;
         StLow:    if (phase_end) state_d = StLaunch;
         StLaunch: if (phase_end) state_d = StSample;
`ifdef STEP_LOG_EN
         StSample: if (phase_end) state_d = StLog;
         StLog:    if (log_ready) state_d = StRecover;
`else
         StSample: if (phase_end) state_d = StRecover;
`endif
         StRecover: if (phase_end) state_d = last_step ? StDone : StSettle;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      busy   = 1'b1;
      done   = 1'b0;
      tclk_o = 1'b0;
      din_o  = 1'b0;
      unique case (state_q)
         StIdle: busy = 1'b0;
         StPrime: tclk_o = 1'b1;
         StLaunch, StSample, StLog: begin
            tclk_o = 1'b1;
            din_o  = 1'b1;
         end
         StDone: begin
            busy = 1'b0;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      tick_d = '0;
      if (timed_phase && !phase_end) begin
         tick_d = tick_q + 1'b1;
      end
   end

   // Sequence counters and per-channel results
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q      <= '0;
         code_q      <= MaxCode;
         stop_q      <= 1'b0;
         failed_q    <= '0;
         found_q     <= '0;
         prime_err_q <= '0;
         for (int ch = 0; ch < int'(NCH); ch++) begin
            min_code_q[ch] <= MaxCode;
         end
      end else begin
         tick_q <= tick_d;
         if (start_ok) begin
            code_q      <= MaxCode;
            stop_q      <= stop_on_fail;
            failed_q    <= '0;
            found_q     <= '0;
            prime_err_q <= '0;
            for (int ch = 0; ch < int'(NCH); ch++) begin
               min_code_q[ch] <= MaxCode;
            end
         end
         if (state_q == StPrime && phase_end) begin
            prime_err_q <= prime_err_q | dout_s;
         end
         // A channel's result only moves while it has never failed in this sweep
         if (state_q == StSample && phase_end) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
               if (dout_s[ch]) begin
                  if (!failed_q[ch]) begin
                     min_code_q[ch] <= code_q;
                     found_q[ch]    <= 1'b1;
                  end
               end else begin
                  failed_q[ch] <= 1'b1;
               end
            end
         end
         if (state_q == StRecover && phase_end && !last_step) begin
            code_q <= code_q - 1'b1;
         end
      end
   end

`ifdef STEP_LOG_EN
   logic [NCH-1:0] log_fail_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         log_fail_q <= '0;
      end else if (state_q == StSample && phase_end) begin
         log_fail_q <= ~dout_s;
      end
   end

   assign log_valid = (state_q == StLog);
   assign log_code  = code_q;
   assign log_fail  = log_fail_q;
`endif

   assign delay_code_o = code_q;
   assign min_code_o   = min_code_q;
   assign found_o      = found_q;
   assign prime_err_o  = prime_err_q;

endmodule

// File: tb/tb_dff_setup_sweep_ctrl.sv
// Self-checking bench for dff_setup_sweep_ctrl: a board model of NCH flip-flops driven by a
// per-channel pass table, with sweep results predicted directly from that table.
module tb_dff_setup_sweep_ctrl;

   localparam int unsigned NCH      = 4;
   localparam int unsigned CODE_W   = 4;
   localparam int unsigned MAX_CODE = 10;
   localparam int unsigned TICK     = 10;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  start = 1'b0;
   logic                  stop_on_fail = 1'b0;
   logic                  busy, done, tclk_o, din_o;
   logic [CODE_W-1:0]     delay_code_o;
   logic [NCH-1:0]        dout_i = '0;
   logic [NCH*CODE_W-1:0] min_code_o;
   logic [NCH-1:0]        found_o, prime_err_o;
`ifdef STEP_LOG_EN
   logic                  log_valid;
   logic                  log_ready = 1'b0;
   logic [CODE_W-1:0]     log_code;
   logic [NCH-1:0]        log_fail;
`endif

   int n_chk = 0;
   int n_bad = 0;
   bit pass_tbl [NCH][16];
   bit stuck [NCH];
   int logv_cycles = 0;
   int log_hs = 0;
   bit stall_mode = 0;
   int stall_cnt = 0;
   logic tclk_prev = 1'b0;

   always #5 clk = ~clk;

   dff_setup_sweep_ctrl #(
      .NCH      (NCH),
      .CODE_W   (CODE_W),
      .MAX_CODE (MAX_CODE),
      .TICK     (TICK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop_on_fail (stop_on_fail),
      .busy         (busy),
      .done         (done),
      .tclk_o       (tclk_o),
      .din_o        (din_o),
      .delay_code_o (delay_code_o),
      .dout_i       (dout_i),
      .min_code_o   (min_code_o),
      .found_o      (found_o),
      .prime_err_o  (prime_err_o)
`ifdef STEP_LOG_EN
      ,
      .log_valid    (log_valid),
      .log_ready    (log_ready),
      .log_code     (log_code),
      .log_fail     (log_fail)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Board: on a test-clock rise each flop captures din if the code meets its setup time;
   // a stuck flop reads 1 after the priming edge.
   always @(negedge clk) begin
      if (tclk_o && !tclk_prev) begin
         for (int k = 0; k < int'(NCH); k++) begin
            dout_i[k] <= din_o ? pass_tbl[k][delay_code_o] : stuck[k];
         end
      end
      tclk_prev = tclk_o;
   end

`ifdef STEP_LOG_EN
   logic [CODE_W-1:0] pcode = '0;
   logic [NCH-1:0]    pfail = '0;
   bit                pvalid = 0;
   bit                phs = 0;

   always @(negedge clk) begin
      bit             hs;
      logic [NCH-1:0] exp_fail;
      if (stall_mode && log_valid && log_code == 4'd8 && stall_cnt < 50) begin
         log_ready = 1'b0;
         stall_cnt++;
         check("log/tclk_held", tclk_o, 1);
      end else begin
         log_ready = ($urandom_range(0, 2) != 0);
      end
      if (log_valid) logv_cycles++;
      if (pvalid && !phs && log_valid) begin
         check("log/code_stable", log_code, pcode);
         check("log/fail_stable", log_fail, pfail);
      end
      hs = log_valid && log_ready;
      if (hs) begin
         for (int k = 0; k < int'(NCH); k++) exp_fail[k] = !pass_tbl[k][log_code];
         check("log/fail_bits", log_fail, exp_fail);
         log_hs++;
      end
      pvalid = log_valid;
      phs    = hs;
      pcode  = log_code;
      pfail  = log_fail;
   end
`endif

   function automatic void set_ideal();
      for (int k = 0; k < int'(NCH); k++) begin
         stuck[k] = 0;
         for (int c = 0; c < 16; c++) pass_tbl[k][c] = 1;
      end
   endfunction

   // Predict from the table, start a sweep, follow it to done and compare all results.
   task automatic run_sweep(input string name, input bit stop);
      int             exp_min [NCH];
      logic [NCH-1:0] exp_found, exp_perr;
      bit             failed [NCH];
      bit             allf;
      int             last, nsteps, j, min_seen;
      exp_found = '0;
      last = MAX_CODE;
      for (int k = 0; k < int'(NCH); k++) begin
         exp_min[k]  = MAX_CODE;
         failed[k]   = 0;
         exp_perr[k] = stuck[k];
      end
      for (int c = MAX_CODE; c >= 0; c--) begin
         last = c;
         allf = 1;
         for (int k = 0; k < int'(NCH); k++) begin
            if (!pass_tbl[k][c]) failed[k] = 1;
            else if (!failed[k]) begin
               exp_min[k]   = c;
               exp_found[k] = 1'b1;
            end
            allf &= failed[k];
         end
         if (stop && allf) break;
      end
      nsteps = MAX_CODE - last + 1;

      @(negedge clk);
      start = 1'b1;
      stop_on_fail = stop;
      @(negedge clk);
      start = 1'b0;
      stop_on_fail = !stop;
      logv_cycles = 0;
      log_hs = 0;
      check({name, "/busy_after_start"}, busy, 1);
      check({name, "/first_code"}, delay_code_o, MAX_CODE);
      j = 0;
      min_seen = MAX_CODE;
      while (!done && j < 4000) begin
         if (int'(delay_code_o) < min_seen) min_seen = delay_code_o;
         @(negedge clk);
         j++;
      end
      check({name, "/cycles"}, j + 2, nsteps * 6 * TICK + 2 + logv_cycles);
      check({name, "/busy_at_done"}, busy, 0);
      check({name, "/lowest_code"}, min_seen, last);
      check({name, "/found"}, found_o, exp_found);
      check({name, "/prime_err"}, prime_err_o, exp_perr);
      for (int k = 0; k < int'(NCH); k++) begin
         check($sformatf("%s/min_code%0d", name, k), min_code_o[k*CODE_W +: CODE_W], exp_min[k]);
      end
`ifdef STEP_LOG_EN
      check({name, "/log_handshakes"}, log_hs, nsteps);
`endif
      @(negedge clk);
      check({name, "/done_one_cycle"}, done, 0);
      check({name, "/idle_not_busy"}, busy, 0);
   endtask

   task automatic reset_mid_sweep();
      int j = 0;
      int extra_done = 0;
      set_ideal();
      @(negedge clk);
      start = 1'b1;
      stop_on_fail = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!(tclk_o && din_o && delay_code_o == 4'd7) && j < 4000) begin
         @(negedge clk);
         j++;
      end
      check("rst/reached_launch7", (j < 4000), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst/tclk", tclk_o, 0);
      check("rst/din", din_o, 0);
      check("rst/busy", busy, 0);
      check("rst/done", done, 0);
      check("rst/found_cleared", found_o, 0);
      check("rst/min_cleared", min_code_o, {NCH{4'(MAX_CODE)}});
      check("rst/code", delay_code_o, MAX_CODE);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("rst/no_done", extra_done, 0);
   endtask

   initial begin
      set_ideal();
      repeat (3) @(negedge clk);
      check("reset/busy", busy, 0);
      check("reset/done", done, 0);
      check("reset/tclk", tclk_o, 0);
      check("reset/din", din_o, 0);
      check("reset/code", delay_code_o, MAX_CODE);
      check("reset/min_code", min_code_o, {NCH{4'(MAX_CODE)}});
      check("reset/found", found_o, 0);
      check("reset/prime_err", prime_err_o, 0);
      rst = 1'b0;

      run_sweep("ideal", 0);

      for (int k = 0; k < int'(NCH); k++)
         for (int c = 0; c < 16; c++) pass_tbl[k][c] = (c >= 3 + k);
      run_sweep("thresh", 0);

      set_ideal();
      for (int c = 0; c < 16; c++) pass_tbl[2][c] = 0;
      run_sweep("ch2_dead", 0);

      for (int k = 0; k < int'(NCH); k++)
         for (int c = 0; c < 16; c++) pass_tbl[k][c] = (c >= 4);
      run_sweep("stop_early", 1);

      set_ideal();
      pass_tbl[0][5] = 0;
      run_sweep("nonmono", 0);

      set_ideal();
      stuck[1] = 1;
      run_sweep("prime_stuck", 0);

      reset_mid_sweep();
      set_ideal();
      run_sweep("after_rst", 0);

`ifdef STEP_LOG_EN
      stall_mode = 1;
      stall_cnt = 0;
      run_sweep("log_stall", 0);
      check("log/stall_len", stall_cnt, 50);
      stall_mode = 0;
`endif

      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < int'(NCH); k++) begin
            int thr;
            thr = $urandom_range(0, 11);
            stuck[k] = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < 16; c++)
               pass_tbl[k][c] = (c >= thr) ^ ($urandom_range(0, 9) == 0);
         end
         run_sweep($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
